// File: rtl/ccc_reconfig_pkg.sv
// Shared definitions for the CCC dynamic-reconfiguration initiator:
// command op codes, FSM encoding and the shared wait-counter width.
package ccc_reconfig_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_RELOCK = 2'b10,
    OP_RSVD   = 2'b11
  } ccc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_ACCESS,
    ST_RELOCK_ARST,
    ST_RELOCK_WAIT,
    ST_RESP
  } ccc_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous CCC status inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator for the CCC reconfiguration port: single commands become
// CCC register reads/writes or a PLL reset-and-relock, with a lock-loss monitor.
//
// state          | meaning
// ST_IDLE        | ready for a command
// ST_WAIT_BUSY   | waiting for CCC BUSY low before an APB transfer
// ST_SETUP       | APB setup phase (PSEL=1, PENABLE=0)
// ST_ACCESS      | APB access phase, fixed one cycle (no PREADY)
// ST_RELOCK_ARST | holding PLL_ARST_N low
// ST_RELOCK_WAIT | waiting for synchronized LOCK
// ST_RESP        | one-cycle response
module ccc_apb_reconfig
  import ccc_reconfig_pkg::*;
#(
  parameter int unsigned ARST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [5:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  output logic       PLL_ARST_N,
  input  logic       LOCK,
  output logic       LOCKED,
  output logic       LOCK_LOST
);

  localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(ARST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  ccc_state_e       state;
  ccc_op_e          op_q;
  logic [5:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             locked_d;
  logic             lock_seen;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (PCLK),
    .rst (RESET),
    .d   (LOCK),
    .q   (LOCKED)
  );

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      CMD_READY  <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
      locked_d   <= 1'b0;
      lock_seen  <= 1'b0;
      LOCK_LOST  <= 1'b0;
    end else begin
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      // One cycle behind the state so the reset pulse spans exactly ARST_CYCLES.
      PLL_ARST_N <= (state != ST_RELOCK_ARST);
      locked_d   <= LOCKED;
      cnt        <= cnt + 1'b1;
      if (LOCKED) lock_seen <= 1'b1;
      if (locked_d && !LOCKED && lock_seen &&
          state != ST_RELOCK_ARST && state != ST_RELOCK_WAIT)
        LOCK_LOST <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (CMD_READY && CMD_VALID) begin
            CMD_READY <= 1'b0;
            op_q      <= ccc_op_e'(CMD_OP);
            addr_q    <= CMD_ADDR;
            wdata_q   <= CMD_WDATA;
            cnt       <= '0;
            case (ccc_op_e'(CMD_OP))
              OP_READ, OP_WRITE: state <= ST_WAIT_BUSY;
              OP_RELOCK:         state <= ST_RELOCK_ARST;
              default: begin
                state     <= ST_RESP;
                RSP_VALID <= 1'b1;
                RSP_ERR   <= 1'b1;
              end
            endcase
          end else begin
            CMD_READY <= 1'b1;
          end
        end
        ST_WAIT_BUSY: begin
          if (!BUSY) begin
            state  <= ST_SETUP;
            cnt    <= '0;
            PSEL   <= 1'b1;
            PADDR  <= addr_q;
            PWDATA <= wdata_q;
            PWRITE <= (op_q == OP_WRITE);
          end else if (cnt == BUSY_LAST) begin
            state     <= ST_RESP;
            cnt       <= '0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          cnt     <= '0;
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          cnt       <= '0;
          RSP_VALID <= 1'b1;
          RSP_RDATA <= (op_q == OP_READ) ? PRDATA : 8'h00;
        end
        ST_RELOCK_ARST: begin
          if (cnt == ARST_LAST) begin
            state <= ST_RELOCK_WAIT;
            cnt   <= '0;
          end
        end
        ST_RELOCK_WAIT: begin
          if (LOCKED) begin
            state     <= ST_RESP;
            cnt       <= '0;
            RSP_VALID <= 1'b1;
            LOCK_LOST <= 1'b0;
          end else if (cnt == LOCK_LAST) begin
            state     <= ST_RESP;
            cnt       <= '0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          CMD_READY <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccc_apb_reconfig.sv
// Directed bench for ccc_apb_reconfig with small timeouts so every path is reachable quickly.
module tb_ccc_apb_reconfig;

  logic       PCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [5:0] CMD_ADDR = 6'h00;
  logic [7:0] CMD_WDATA = 8'h00;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERR;
  logic       PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       BUSY = 1'b0;
  logic       PLL_ARST_N;
  logic       LOCK = 1'b0;
  logic       LOCKED;
  logic       LOCK_LOST;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  // CCC register model: drives read data only during the access phase.
  assign PRDATA = (PSEL && PENABLE) ? 8'hA7 : 8'h00;

  ccc_apb_reconfig #(
    .ARST_CYCLES (4),
    .LOCK_TIMEOUT(100),
    .BUSY_TIMEOUT(8)
  ) dut (
    .PCLK(PCLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .BUSY(BUSY), .PLL_ARST_N(PLL_ARST_N),
    .LOCK(LOCK), .LOCKED(LOCKED), .LOCK_LOST(LOCK_LOST)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Presents a command and returns in cycle T0 (just after the accepting edge).
  task automatic send(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wd);
    int guard = 0;
    CMD_OP = op; CMD_ADDR = addr; CMD_WDATA = wd; CMD_VALID = 1'b1;
    while (!CMD_READY && guard < 50) begin tick(); guard++; end
    n_cmp++;
    if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL send_ready: CMD_READY=%b required 1", CMD_READY); end
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; LOCK = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({CMD_READY, RSP_VALID, RSP_ERR, PSEL, PENABLE, PWRITE, PLL_ARST_N, LOCKED, LOCK_LOST} !== 9'b000000100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 000000100",
               {CMD_READY, RSP_VALID, RSP_ERR, PSEL, PENABLE, PWRITE, PLL_ARST_N, LOCKED, LOCK_LOST});
    end
    n_cmp++;
    if ({RSP_RDATA, PADDR, PWDATA} !== 22'h0) begin
      n_bad++; $display("FAIL reset_data: rdata=%h paddr=%h pwdata=%h required 0", RSP_RDATA, PADDR, PWDATA);
    end
    RESET = 1'b0;
    tick();
    n_cmp++;
    if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: CMD_READY=%b required 1", CMD_READY); end
    LOCK = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ({LOCKED, LOCK_LOST} !== 2'b10) begin n_bad++; $display("FAIL initial_lock: LOCKED/LOCK_LOST=%b required 10", {LOCKED, LOCK_LOST}); end
  endtask

  task automatic test_write();
    send(2'b01, 6'h0A, 8'h5C);
    n_cmp++;
    if ({CMD_READY, PSEL} !== 2'b00) begin n_bad++; $display("FAIL wr_t0: READY/PSEL=%b required 00", {CMD_READY, PSEL}); end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 6'h0A, 8'h5C}) begin
      n_bad++; $display("FAIL wr_setup: sel/en/wr=%b addr=%h wdata=%h required 101 0a 5c", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 6'h0A, 8'h5C}) begin
      n_bad++; $display("FAIL wr_access: sel/en/wr=%b addr=%h wdata=%h required 111 0a 5c", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, PSEL, PENABLE, RSP_RDATA} !== {4'b1000, 8'h00}) begin
      n_bad++; $display("FAIL wr_resp: valid/err/sel/en=%b rdata=%h required 1000 00", {RSP_VALID, RSP_ERR, PSEL, PENABLE}, RSP_RDATA);
    end
    tick();
    n_cmp++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin n_bad++; $display("FAIL wr_t4: VALID/READY=%b required 01", {RSP_VALID, CMD_READY}); end
  endtask

  task automatic test_read_busy();
    int early = 0;
    BUSY = 1'b1;
    send(2'b00, 6'h03, 8'hFF);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (PSEL) early++;
      if (i == 5) BUSY = 1'b0;
    end
    n_cmp++;
    if (early !== 0) begin n_bad++; $display("FAIL rd_busy_hold: PSEL high %0d cycles while busy, required 0", early); end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 6'h03}) begin
      n_bad++; $display("FAIL rd_setup_t6: sel/en/wr=%b addr=%h required 100 03", {PSEL, PENABLE, PWRITE}, PADDR);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rd_access_t7: sel/en=%b required 11", {PSEL, PENABLE}); end
    tick();
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {2'b10, 8'hA7}) begin
      n_bad++; $display("FAIL rd_resp_t8: valid/err=%b rdata=%h required 10 a7", {RSP_VALID, RSP_ERR}, RSP_RDATA);
    end
  endtask

  task automatic test_busy_timeout();
    int sel_seen = 0;
    int rsp_early = 0;
    tick();
    BUSY = 1'b1;
    send(2'b00, 6'h11, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (PSEL) sel_seen++;
      if (RSP_VALID) rsp_early++;
    end
    tick();
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {2'b11, 8'h00}) begin
      n_bad++; $display("FAIL busy_to_resp_t8: valid/err=%b rdata=%h required 11 00", {RSP_VALID, RSP_ERR}, RSP_RDATA);
    end
    n_cmp++;
    if (sel_seen + rsp_early + int'(PSEL) !== 0) begin
      n_bad++; $display("FAIL busy_to_quiet: psel cycles=%0d early rsp=%0d required 0 0", sel_seen + int'(PSEL), rsp_early);
    end
    BUSY = 1'b0;
    tick();
    n_cmp++;
    if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL busy_to_ready: CMD_READY=%b required 1", CMD_READY); end
  endtask

  task automatic test_lock_loss();
    n_cmp++;
    if (LOCK_LOST !== 1'b0) begin n_bad++; $display("FAIL loss_pre: LOCK_LOST=%b required 0", LOCK_LOST); end
    LOCK = 1'b0;
    tick();
    n_cmp++;
    if (LOCK_LOST !== 1'b0) begin n_bad++; $display("FAIL loss_early: LOCK_LOST=%b required 0", LOCK_LOST); end
    repeat (2) tick();
    LOCK = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (LOCK_LOST !== 1'b1) begin n_bad++; $display("FAIL loss_set: LOCK_LOST=%b required 1", LOCK_LOST); end
    repeat (5) tick();
    n_cmp++;
    if ({LOCKED, LOCK_LOST} !== 2'b11) begin n_bad++; $display("FAIL loss_sticky: LOCKED/LOCK_LOST=%b required 11", {LOCKED, LOCK_LOST}); end
  endtask

  task automatic test_reserved();
    send(2'b11, 6'h3F, 8'hFF);
    n_cmp++;
    if ({RSP_VALID, RSP_ERR, PSEL, PENABLE, RSP_RDATA} !== {4'b1100, 8'h00}) begin
      n_bad++; $display("FAIL rsvd_resp: valid/err/sel/en=%b rdata=%h required 1100 00", {RSP_VALID, RSP_ERR, PSEL, PENABLE}, RSP_RDATA);
    end
    tick();
    n_cmp++;
    if ({RSP_VALID, PSEL, CMD_READY} !== 3'b001) begin n_bad++; $display("FAIL rsvd_after: valid/sel/ready=%b required 001", {RSP_VALID, PSEL, CMD_READY}); end
  endtask

  // lock_delay < 0 models a PLL that never relocks.
  task automatic test_relock(input int lock_delay, input int exp_idx, input logic exp_err,
                             input logic exp_locked, input logic exp_lost);
    int low_cnt = 0;
    int first_low = -1;
    int rel_idx = -1;
    int rsp_idx = -1;
    send(2'b10, 6'h00, 8'h00);
    n_cmp++;
    if (PLL_ARST_N !== 1'b1) begin n_bad++; $display("FAIL relock_t0: PLL_ARST_N=%b required 1", PLL_ARST_N); end
    for (int idx = 1; idx <= 300; idx++) begin
      tick();
      if (PLL_ARST_N === 1'b0) begin
        low_cnt++;
        LOCK = 1'b0;
        if (first_low < 0) first_low = idx;
      end else if (first_low >= 0 && rel_idx < 0) begin
        rel_idx = idx;
      end
      if (lock_delay >= 0 && rel_idx >= 0 && idx == rel_idx + lock_delay) LOCK = 1'b1;
      if (RSP_VALID) begin rsp_idx = idx; break; end
    end
    n_cmp++;
    if ({first_low, low_cnt} !== {32'sd1, 32'sd4}) begin
      n_bad++; $display("FAIL relock_arst: first low T%0d for %0d cycles, required T1 for 4", first_low, low_cnt);
    end
    n_cmp++;
    if (rsp_idx !== exp_idx) begin n_bad++; $display("FAIL relock_rsp_time: RSP_VALID at T%0d required T%0d", rsp_idx, exp_idx); end
    n_cmp++;
    if ({RSP_ERR, LOCKED, LOCK_LOST} !== {exp_err, exp_locked, exp_lost}) begin
      n_bad++; $display("FAIL relock_status: err/locked/lost=%b required %b", {RSP_ERR, LOCKED, LOCK_LOST}, {exp_err, exp_locked, exp_lost});
    end
    tick();
  endtask

  task automatic test_reset_in_access();
    int stray = 0;
    send(2'b01, 6'h2A, 8'h33);
    repeat (2) tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rst_acc_pre: sel/en=%b required 11", {PSEL, PENABLE}); end
    RESET = 1'b1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, RSP_VALID, CMD_READY, PLL_ARST_N, LOCKED, LOCK_LOST} !== 7'b0000100 || PADDR !== 6'h00) begin
      n_bad++; $display("FAIL rst_acc_out: sel/en/valid/ready/arst/locked/lost=%b paddr=%h required 0000100 00",
                        {PSEL, PENABLE, RSP_VALID, CMD_READY, PLL_ARST_N, LOCKED, LOCK_LOST}, PADDR);
    end
    RESET = 1'b0;
    tick();
    n_cmp++;
    if ({CMD_READY, RSP_VALID} !== 2'b10) begin n_bad++; $display("FAIL rst_acc_release: ready/valid=%b required 10", {CMD_READY, RSP_VALID}); end
    for (int i = 0; i < 5; i++) begin tick(); if (RSP_VALID || PSEL) stray++; end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL rst_acc_dropped: %0d stray cycles, required 0", stray); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_busy();
    test_busy_timeout();
    test_lock_loss();
    test_reserved();
    test_relock(-1, 104, 1'b1, 1'b0, 1'b1);
    test_relock(50, 58, 1'b0, 1'b1, 1'b0);
    test_reset_in_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
